// File: rtl/disp_pkg.sv
// Shared types and constants for the display BCD converter.
package disp_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } state_t;

  localparam int          DATA_W  = 32;
  localparam int          DIGITS  = 8;
  localparam int          CNT_W   = 5;
  localparam logic [31:0] BCD_MAX = 32'd99_999_999;
  localparam logic [31:0] BCD_SAT = 32'h9999_9999;

endpackage

// File: rtl/disp_bcd_conv_if.sv
// Request/result bundle between a display controller and disp_bcd_conv.
interface disp_bcd_conv_if;
  import disp_pkg::*;

  logic              start;
  logic [DATA_W-1:0] bin;
  logic              busy;
  logic              done;
  logic [DATA_W-1:0] bcd;
  logic              ovf;
  logic              neg;

  modport master (output start, bin, input busy, done, bcd, ovf, neg);
  modport slave  (input start, bin, output busy, done, bcd, ovf, neg);

endinterface

// File: rtl/bcd_digit_adj.sv
// Double-dabble nibble correction: add 3 to any BCD digit of 5 or more.
module bcd_digit_adj (
  input  logic [3:0] din,
  output logic [3:0] dout
);

  assign dout = (din >= 4'd5) ? din + 4'd3 : din;

endmodule

// File: rtl/disp_bcd_conv.sv
// Serial 32-bit binary to 8-digit BCD converter (double dabble, 32 shift cycles).
// Define DISP_BCD_SIGNED_EN to treat bin as two's complement and report the sign on neg.
module disp_bcd_conv
  import disp_pkg::*;
(
  input  logic             clk,
  input  logic             rst_n,
  disp_bcd_conv_if.slave   bus
);

  state_t            state, state_nxt;
  logic [DATA_W-1:0] acc, acc_adj, sr;
  logic [CNT_W-1:0]  cnt;
  logic              ovf_p, neg_p;
  logic [DATA_W-1:0] mag;
  logic              neg_in;
  logic [DATA_W-1:0] bcd_q;
  logic              ovf_q, neg_q, done_q;

  function automatic logic is_ovf(input logic [DATA_W-1:0] m);
    return (m > BCD_MAX);
  endfunction

  function automatic logic [DATA_W-1:0] sat_bcd(input logic [DATA_W-1:0] digits,
                                                 input logic            sat);
    return sat ? BCD_SAT : digits;
  endfunction

`ifdef DISP_BCD_SIGNED_EN
  logic signed [DATA_W-1:0] bin_s;
  assign bin_s = signed'(bus.bin);

  // -(-2^31) wraps back to 2^31 as an unsigned magnitude, which then overflows.
  always_comb begin
    neg_in = 1'b0;
    mag    = bus.bin;
    if (bin_s < 0) begin
      neg_in = 1'b1;
      mag    = unsigned'(-bin_s);
    end
  end
`else
  always_comb begin
    neg_in = 1'b0;
    mag    = bus.bin;
  end
`endif

  for (genvar g = 0; g < DIGITS; g++) begin : g_adj
    bcd_digit_adj u_adj (
      .din  (acc[4*g +: 4]),
      .dout (acc_adj[4*g +: 4])
    );
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (bus.start) state_nxt = SHIFT;
      SHIFT:   if (cnt == 5'd31) state_nxt = DONE;
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      acc    <= '0;
      sr     <= '0;
      cnt    <= '0;
      ovf_p  <= 1'b0;
      neg_p  <= 1'b0;
      bcd_q  <= '0;
      ovf_q  <= 1'b0;
      neg_q  <= 1'b0;
      done_q <= 1'b0;
    end else begin
      done_q <= (state == DONE);
      case (state)
        IDLE: begin
          if (bus.start) begin
            sr    <= mag;
            acc   <= '0;
            cnt   <= '0;
            ovf_p <= is_ovf(mag);
            neg_p <= neg_in;
          end
        end
        SHIFT: begin
          {acc, sr} <= {acc_adj, sr} << 1;
          if (cnt != 5'd31) cnt <= cnt + 5'd1;
        end
        DONE: begin
          bcd_q <= sat_bcd(acc, ovf_p);
          ovf_q <= ovf_p;
          neg_q <= neg_p;
        end
        default: ;
      endcase
    end
  end

  assign bus.busy = (state != IDLE);
  assign bus.done = done_q;
  assign bus.bcd  = bcd_q;
  assign bus.ovf  = ovf_q;
  assign bus.neg  = neg_q;

endmodule

// File: tb/tb_disp_bcd_conv.sv
// Directed bench for disp_bcd_conv; expected values are hand-computed BCD constants.
module tb_disp_bcd_conv;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   n_checks = 0;
  int   n_fail = 0;

  always #5 clk = ~clk;

  disp_bcd_conv_if bus ();

  disp_bcd_conv dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Issues one start pulse, then scrambles bin so only the accept edge may sample it.
  task automatic run_conv(input logic [31:0] b, output int cyc, output int bcnt, output bit held);
    logic [31:0] prev;
    @(negedge clk);
    prev      = bus.bcd;
    bus.start = 1'b1;
    bus.bin   = b;
    @(negedge clk);
    bus.start = 1'b0;
    bus.bin   = ~b;
    cyc  = 0;
    bcnt = 0;
    held = 1'b1;
    while (!bus.done && cyc < 100) begin
      if (bus.busy) bcnt++;
      if (bus.bcd !== prev) held = 1'b0;
      @(negedge clk);
      cyc++;
    end
  endtask

  int  cyc, bcnt, dones, r0, r1, r2;
  bit  held, pb;
  int  rises[$];

  initial begin
    bus.start = 1'b0;
    bus.bin   = '0;
    rst_n     = 1'b0;
    repeat (2) @(negedge clk);
    check_val("rst_busy", 32'(bus.busy), 32'd0);
    check_val("rst_done", 32'(bus.done), 32'd0);
    check_val("rst_bcd",  bus.bcd,       32'd0);
    check_val("rst_ovf",  32'(bus.ovf),  32'd0);
    check_val("rst_neg",  32'(bus.neg),  32'd0);
    rst_n = 1'b1;

    run_conv(32'd12345678, cyc, bcnt, held);
    check_val("c1_latency", 32'(cyc),      32'd33);
    check_val("c1_busy_cyc", 32'(bcnt),    32'd33);
    check_val("c1_done",    32'(bus.done), 32'd1);
    check_val("c1_busy_lo", 32'(bus.busy), 32'd0);
    check_val("c1_bcd",     bus.bcd,       32'h1234_5678);
    check_val("c1_ovf",     32'(bus.ovf),  32'd0);
    check_val("c1_neg",     32'(bus.neg),  32'd0);
    @(negedge clk);
    check_val("c1_done_pulse", 32'(bus.done), 32'd0);
    check_val("c1_bcd_hold",   bus.bcd,       32'h1234_5678);

    run_conv(32'd99_999_999, cyc, bcnt, held);
    check_val("max_bcd", bus.bcd,      32'h9999_9999);
    check_val("max_ovf", 32'(bus.ovf), 32'd0);

    run_conv(32'd100_000_000, cyc, bcnt, held);
    check_val("ovf_bcd", bus.bcd,      32'h9999_9999);
    check_val("ovf_ovf", 32'(bus.ovf), 32'd1);

    run_conv(32'd0, cyc, bcnt, held);
    check_val("zero_held", 32'(held),     32'd1);
    check_val("zero_bcd",  bus.bcd,       32'd0);
    check_val("zero_ovf",  32'(bus.ovf),  32'd0);
    check_val("zero_neg",  32'(bus.neg),  32'd0);

    // Start held high: accepts expected at edges 0, 34 and 68.
    @(negedge clk);
    bus.start = 1'b1;
    bus.bin   = 32'd5;
    dones = 0;
    pb    = 1'b0;
    for (int n = 0; n <= 101; n++) begin
      @(negedge clk);
      if (bus.busy && !pb) rises.push_back(n);
      pb = bus.busy;
      if (bus.done) dones++;
    end
    bus.start = 1'b0;
    r0 = (rises.size() > 0) ? rises[0] : -1;
    r1 = (rises.size() > 1) ? rises[1] : -1;
    r2 = (rises.size() > 2) ? rises[2] : -1;
    check_val("hold_accepts", 32'(rises.size()), 32'd3);
    check_val("hold_edge0",   32'(r0),    32'd0);
    check_val("hold_edge34",  32'(r1),    32'd34);
    check_val("hold_edge68",  32'(r2),    32'd68);
    check_val("hold_dones",   32'(dones), 32'd3);
    check_val("hold_bcd",     bus.bcd,    32'h0000_0005);
    repeat (3) @(negedge clk);

    // Reset in the middle of a conversion.
    @(negedge clk);
    bus.start = 1'b1;
    bus.bin   = 32'd12345678;
    @(negedge clk);
    bus.start = 1'b0;
    repeat (9) @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk);
    check_val("mid_rst_busy", 32'(bus.busy), 32'd0);
    check_val("mid_rst_done", 32'(bus.done), 32'd0);
    check_val("mid_rst_bcd",  bus.bcd,       32'd0);
    check_val("mid_rst_ovf",  32'(bus.ovf),  32'd0);
    check_val("mid_rst_neg",  32'(bus.neg),  32'd0);
    rst_n = 1'b1;
    dones = 0;
    repeat (40) begin
      @(negedge clk);
      if (bus.done) dones++;
    end
    check_val("mid_rst_no_done", 32'(dones), 32'd0);
    run_conv(32'd7, cyc, bcnt, held);
    check_val("post_rst_lat", 32'(cyc), 32'd33);
    check_val("post_rst_bcd", bus.bcd,  32'h0000_0007);

`ifdef DISP_BCD_SIGNED_EN
    run_conv(32'hFFFF_FFFF, cyc, bcnt, held);
    check_val("sgn_m1_bcd", bus.bcd,      32'h0000_0001);
    check_val("sgn_m1_neg", 32'(bus.neg), 32'd1);
    check_val("sgn_m1_ovf", 32'(bus.ovf), 32'd0);
    run_conv(32'h8000_0000, cyc, bcnt, held);
    check_val("sgn_min_ovf", 32'(bus.ovf), 32'd1);
    check_val("sgn_min_neg", 32'(bus.neg), 32'd1);
    check_val("sgn_min_bcd", bus.bcd,      32'h9999_9999);
`else
    run_conv(32'hFFFF_FFFF, cyc, bcnt, held);
    check_val("uns_ff_bcd", bus.bcd,      32'h9999_9999);
    check_val("uns_ff_ovf", 32'(bus.ovf), 32'd1);
    check_val("uns_ff_neg", 32'(bus.neg), 32'd0);
    run_conv(32'h8000_0000, cyc, bcnt, held);
    check_val("uns_msb_ovf", 32'(bus.ovf), 32'd1);
    check_val("uns_msb_neg", 32'(bus.neg), 32'd0);
`endif

    run_conv(32'd42, cyc, bcnt, held);
    check_val("pos_bcd", bus.bcd,      32'h0000_0042);
    check_val("pos_neg", 32'(bus.neg), 32'd0);
    check_val("pos_ovf", 32'(bus.ovf), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/disp_bcd_conv.md
DISP_BCD_CONV -- requirements
Module: disp_bcd_conv

Interface
REQ-001 The block SHALL have port clk, input, 1 bit, rising-edge clock.
REQ-002 The block SHALL have port rst_n, input, 1 bit, asynchronous active-low reset.
REQ-003 The block SHALL have port start, input, 1 bit, conversion request; sampled only in IDLE.
REQ-004 The block SHALL have port bin, input, 32 bits, binary value; sampled on the edge that accepts start.
REQ-005 The block SHALL have port busy, output, 1 bit, high while a conversion is in progress.
REQ-006 The block SHALL have port done, output, 1 bit, one-cycle pulse when a result is written.
REQ-007 The block SHALL have port bcd, output, 32 bits, 8 packed BCD digits, digit 7 in [31:28]; drives the display data bits [31:0].
REQ-008 The block SHALL have port ovf, output, 1 bit, set when the magnitude exceeds 99_999_999.
REQ-009 The block SHALL have port neg, output, 1 bit, sign of the last converted value.

Function
REQ-010 The FSM SHALL have states IDLE, SHIFT and DONE: IDLE->SHIFT on start; SHIFT->DONE after 32 shift cycles; DONE->IDLE unconditionally.
REQ-011 On the edge accepting start (edge 0), the block SHALL load the magnitude of bin into the shift register, clear the BCD accumulator and clear the 5-bit iteration counter.
REQ-012 On each SHIFT edge (edges 1..32), the block SHALL add 3 to every accumulator nibble >= 5, then shift {accumulator, shift register} left by one bit.
REQ-013 At edge 33 (the DONE state), the block SHALL update bcd, ovf and neg and pulse done high for exactly one cycle.
REQ-014 busy SHALL be high from after edge 0 until edge 33, and low otherwise.
REQ-015 start SHALL be ignored while busy is high or while in DONE; the earliest re-accept edge is edge 34.
REQ-016 Overflow (magnitude > 99_999_999) SHALL be decided at load; on overflow, bcd SHALL saturate to 32'h9999_9999 with ovf=1.
REQ-017 bin = 99_999_999 SHALL produce bcd=32'h9999_9999 with ovf=0.
REQ-018 bcd, ovf and neg SHALL hold their values between conversions and change only at DONE.
REQ-019 The iteration counter SHALL never wrap; the SHIFT exit SHALL occur at counter value 31.

Reset
REQ-020 Asserting rst_n low SHALL force state IDLE and set busy=0, done=0, bcd=0, ovf=0, neg=0, with all internal registers cleared.
REQ-021 A reset during SHIFT SHALL abort the conversion without a done pulse; the next start SHALL then convert normally.

Configuration
REQ-022 The macro DISP_BCD_SIGNED_EN SHALL control signed conversion.
REQ-023 With DISP_BCD_SIGNED_EN defined, bin SHALL be two's complement: magnitude = -bin when bin[31]=1, and neg SHALL equal bin[31] at DONE.
REQ-024 With DISP_BCD_SIGNED_EN defined, 32'h8000_0000 SHALL yield ovf=1 and neg=1.
REQ-025 Without DISP_BCD_SIGNED_EN, bin SHALL be unsigned and neg SHALL be constant 0.

Structure
REQ-026 The shared package disp_pkg SHALL hold the state enum, DIGITS=8, BCD_MAX=99_999_999 and BCD_SAT=32'h9999_9999.
REQ-027 The combinational add-3 nibble correction SHALL be the sub-module bcd_digit_adj, instantiated 8 times.

Verification
REQ-028 The bench SHALL cover: unsigned bin=32'd12345678, start pulse -> done at edge 33, bcd=32'h1234_5678, ovf=0, busy high for 33 cycles.
REQ-029 The bench SHALL cover: bin=32'd99_999_999 -> bcd=32'h9999_9999, ovf=0; bin=32'd100_000_000 -> bcd=32'h9999_9999, ovf=1.
REQ-030 The bench SHALL cover: start held high continuously -> conversions accepted only at edges 0, 34, 68; exactly one done per conversion.
REQ-031 The bench SHALL cover: rst_n low at edge 10 of a conversion -> all outputs 0, no done pulse; a following start with bin=32'd7 -> bcd=32'h0000_0007.
REQ-032 The bench SHALL cover, with DISP_BCD_SIGNED_EN: bin=32'hFFFF_FFFF -> bcd=32'h0000_0001, neg=1; bin=32'h8000_0000 -> ovf=1, neg=1.
REQ-033 The bench SHALL cover: bin=0 -> bcd=0, ovf=0, neg=0, and the previous bcd held until the done edge.
